nand_logic_unit: RTL

Parametrised, two-stage pipelined bitwise logic unit whose datapath is built exclusively from 2-input NAND expressions. It generalises the single-bit NAND-built OR gate to WIDTH bits, eight selectable operations and a valid/ready stream interface. It sits between operand producers and result consumers in the gate-level teaching datapath.

---
 rtl/nand_logic_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nand_logic_unit.sv
// Two-stage pipelined WIDTH-bit logic unit whose datapath uses only 2-input NAND terms.
// Optional status outputs (out_zero, op_count) are built when NLU_STATUS_EN is defined.
module nand_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef NLU_STATUS_EN
  ,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_param_check
    $error("nand_logic_unit: WIDTH must be 1..64 and CNT_W at least 1");
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] n_a, n_b, n_ab, r_and, r_or, r_nor, x_a, x_b, r_xor, r_xnor, r_pass;
  logic [WIDTH-1:0] res;

  // Handshake: S2 frees when empty or drained; S1 frees when empty or moving into S2.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = s1_load;
  end

  always_comb begin
    n_a    = nand2(s1_a, s1_a);
    n_b    = nand2(s1_b, s1_b);
    n_ab   = nand2(s1_a, s1_b);
    r_and  = nand2(n_ab, n_ab);
    r_or   = nand2(n_a, n_b);
    r_nor  = nand2(r_or, r_or);
    x_a    = nand2(s1_a, n_ab);
    x_b    = nand2(s1_b, n_ab);
    r_xor  = nand2(x_a, x_b);
    r_xnor = nand2(r_xor, r_xor);
    r_pass = nand2(n_a, n_a);
    res    = '0;
    unique case (s1_op)
      OP_AND:  res = r_and;
      OP_OR:   res = r_or;
      OP_NAND: res = n_ab;
      OP_NOR:  res = r_nor;
      OP_XOR:  res = r_xor;
      OP_XNOR: res = r_xnor;
      OP_NOTA: res = n_a;
      OP_PASS: res = r_pass;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= op_e'(in_op);
      end
    end
  end

  // A bubble moving into S2 clears the valid bit but leaves the old result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_y <= res;
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;

`ifdef NLU_STATUS_EN
  logic             s2_zero;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero <= 1'b1;
      cnt     <= '0;
    end else begin
      if (s2_load && s1_valid) s2_zero <= (res == '0);
      if (s2_valid && out_ready) cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_zero = s2_zero;
  assign op_count = cnt;
`endif

endmodule
